// File: rtl/strassen_pkg.sv
// Shared widths, pipeline depths and beat types for the Strassen 2x2 multiply core.
package strassen_pkg;

  localparam int DW_DEFAULT = 16;

  function automatic int pre_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int mul_w(input int dw);
    return 2 * dw + 2;
  endfunction

  function automatic int comb_w(input int dw);
    return 2 * dw + 4;
  endfunction

  localparam int PRE_W  = pre_w(DW_DEFAULT);
  localparam int MUL_W  = mul_w(DW_DEFAULT);
  localparam int COMB_W = comb_w(DW_DEFAULT);

  localparam int PIPE_DEPTH_BASE = 3;
  localparam int PIPE_DEPTH_ACC  = 4;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } sb_t;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] e11;
    logic signed [DW_DEFAULT-1:0] e12;
    logic signed [DW_DEFAULT-1:0] e21;
    logic signed [DW_DEFAULT-1:0] e22;
  } mat2_t;

endpackage

// File: rtl/strassen_presum.sv
// Stage 1: the ten Strassen pre-sums plus the four pass-through operands, one
// operand pair per product M1..M7 (index 0 = M1), all at DW+1 bits.
module strassen_presum
  import strassen_pkg::*;
#(
  parameter int DW = 16,
  localparam int PW = pre_w(DW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  sb_t                 beat_sb,
  input  logic [DW-1:0]       a11,
  input  logic [DW-1:0]       a12,
  input  logic [DW-1:0]       a21,
  input  logic [DW-1:0]       a22,
  input  logic [DW-1:0]       b11,
  input  logic [DW-1:0]       b12,
  input  logic [DW-1:0]       b21,
  input  logic [DW-1:0]       b22,
  output sb_t                 stage_sb,
  output logic [6:0][PW-1:0]  op_a,
  output logic [6:0][PW-1:0]  op_b
);

  function automatic logic [PW-1:0] ext(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  logic [PW-1:0] ea11, ea12, ea21, ea22, eb11, eb12, eb21, eb22;

  assign ea11 = ext(a11);
  assign ea12 = ext(a12);
  assign ea21 = ext(a21);
  assign ea22 = ext(a22);
  assign eb11 = ext(b11);
  assign eb12 = ext(b12);
  assign eb21 = ext(b21);
  assign eb22 = ext(b22);

  // One extra bit of headroom makes every sum and difference exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_sb <= '0;
      op_a     <= '0;
      op_b     <= '0;
    end else if (en) begin
      stage_sb <= beat_sb;
      op_a[0]  <= ea11 + ea22;
      op_b[0]  <= eb11 + eb22;
      op_a[1]  <= ea21 + ea22;
      op_b[1]  <= eb11;
      op_a[2]  <= ea11;
      op_b[2]  <= eb12 - eb22;
      op_a[3]  <= ea22;
      op_b[3]  <= eb21 - eb11;
      op_a[4]  <= ea11 + ea12;
      op_b[4]  <= eb22;
      op_a[5]  <= ea21 - ea11;
      op_b[5]  <= eb11 + eb12;
      op_a[6]  <= ea12 - ea22;
      op_b[6]  <= eb21 + eb22;
    end
  end

endmodule

// File: rtl/strassen_2x2_pipe.sv
// Pipelined signed 2x2 matrix multiplier (Strassen, seven products).
// Define STRASSEN_ACC_EN to add a stage-4 group accumulator (C += A*B).
module strassen_2x2_pipe
  import strassen_pkg::*;
#(
  parameter int DW = 16,
  parameter int OW = 2 * DW + 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_first,
  input  logic          in_last,
  input  logic [DW-1:0] a11,
  input  logic [DW-1:0] a12,
  input  logic [DW-1:0] a21,
  input  logic [DW-1:0] a22,
  input  logic [DW-1:0] b11,
  input  logic [DW-1:0] b12,
  input  logic [DW-1:0] b21,
  input  logic [DW-1:0] b22,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] c11,
  output logic [OW-1:0] c12,
  output logic [OW-1:0] c21,
  output logic [OW-1:0] c22
);

  localparam int PW = pre_w(DW);
  localparam int MW = mul_w(DW);
  localparam int CW = comb_w(DW);
  localparam int XW = (OW > CW) ? OW : CW;

  // Handshake: a beat transfers on any edge where valid & ready are both 1.
  // One enable moves the whole pipeline; it is high whenever the output slot
  // is empty or being retired, so in_ready never looks at in_valid.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  sb_t sb0, sb1, sb2, sb3;
  assign sb0 = '{valid: in_valid, first: in_first, last: in_last};

  logic [6:0][PW-1:0] op_a, op_b;

  strassen_presum #(.DW(DW)) u_presum (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .beat_sb  (sb0),
    .a11      (a11),
    .a12      (a12),
    .a21      (a21),
    .a22      (a22),
    .b11      (b11),
    .b12      (b12),
    .b21      (b21),
    .b22      (b22),
    .stage_sb (sb1),
    .op_a     (op_a),
    .op_b     (op_b)
  );

  function automatic logic [MW-1:0] sxm(input logic [PW-1:0] v);
    return {{(MW-PW){v[PW-1]}}, v};
  endfunction

  function automatic logic [XW-1:0] sxc(input logic [MW-1:0] v);
    return {{(XW-MW){v[MW-1]}}, v};
  endfunction

  // Stage 2: the low MW bits of the widened product are the exact signed product.
  logic [6:0][MW-1:0] m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb2 <= '0;
      m   <= '0;
    end else if (en) begin
      sb2 <= sb1;
      for (int i = 0; i < 7; i++) begin
        m[i] <= sxm(op_a[i]) * sxm(op_b[i]);
      end
    end
  end

  logic [XW-1:0] x11, x12, x21, x22;

  always_comb begin
    x11 = sxc(m[0]) + sxc(m[3]) - sxc(m[4]) + sxc(m[6]);
    x12 = sxc(m[2]) + sxc(m[4]);
    x21 = sxc(m[1]) + sxc(m[3]);
    x22 = sxc(m[0]) - sxc(m[1]) + sxc(m[2]) + sxc(m[5]);
  end

  // Stage 3 result, element [3] = C11 down to [0] = C22.
  logic [3:0][OW-1:0] r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb3 <= '0;
      r   <= '0;
    end else if (en) begin
      sb3 <= sb2;
      if (sb2.valid) begin
        r <= {x11[OW-1:0], x12[OW-1:0], x21[OW-1:0], x22[OW-1:0]};
      end
    end
  end

`ifdef STRASSEN_ACC_EN
  logic [3:0][OW-1:0] acc, sum, o;
  logic               ov;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = (sb3.first ? '0 : acc[i]) + r[i];
    end
  end

  // A last beat emits its group total and leaves acc at zero for the next group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      o   <= '0;
      ov  <= 1'b0;
    end else if (en) begin
      ov <= sb3.valid & sb3.last;
      if (sb3.valid) begin
        if (sb3.last) begin
          o   <= sum;
          acc <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign out_valid = ov;
  assign c11 = o[3];
  assign c12 = o[2];
  assign c21 = o[1];
  assign c22 = o[0];
`else
  logic sb_unused;
  assign sb_unused = &{1'b0, sb3.first, sb3.last};

  assign out_valid = sb3.valid;
  assign c11 = r[3];
  assign c12 = r[2];
  assign c21 = r[1];
  assign c22 = r[0];
`endif

endmodule

// File: tb/tb_strassen_2x2_pipe.sv
// Bench for strassen_2x2_pipe; follows STRASSEN_ACC_EN like the design does.
module tb_strassen_2x2_pipe;
  import strassen_pkg::*;

  localparam int DW = 16;
  localparam int OW = 2 * DW + 4;
`ifdef STRASSEN_ACC_EN
  localparam int LAT = PIPE_DEPTH_ACC;
`else
  localparam int LAT = PIPE_DEPTH_BASE;
`endif

  typedef logic [3:0][OW-1:0] cvec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] a11 = '0, a12 = '0, a21 = '0, a22 = '0;
  logic [DW-1:0] b11 = '0, b12 = '0, b21 = '0, b22 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] c11, c12, c21, c22;

  logic [4*OW-1:0] exp_q[$];
  cvec_t           m_acc = '0;
  int              checks = 0;
  int              errors = 0;

  strassen_2x2_pipe #(.DW(DW), .OW(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .a11       (a11),
    .a12       (a12),
    .a21       (a21),
    .a22       (a22),
    .b11       (b11),
    .b12       (b12),
    .b21       (b21),
    .b22       (b22),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c11       (c11),
    .c12       (c12),
    .c21       (c21),
    .c22       (c22)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint sv(input logic signed [DW-1:0] v);
    return longint'(v);
  endfunction

  function automatic cvec_t cv(input longint p11, input longint p12, input longint p21, input longint p22);
    cvec_t res;
    res[3] = p11[OW-1:0];
    res[2] = p12[OW-1:0];
    res[1] = p21[OW-1:0];
    res[0] = p22[OW-1:0];
    return res;
  endfunction

  function automatic cvec_t matmul(input mat2_t x, input mat2_t y);
    return cv(sv(x.e11) * sv(y.e11) + sv(x.e12) * sv(y.e21),
              sv(x.e11) * sv(y.e12) + sv(x.e12) * sv(y.e22),
              sv(x.e21) * sv(y.e11) + sv(x.e22) * sv(y.e21),
              sv(x.e21) * sv(y.e12) + sv(x.e22) * sv(y.e22));
  endfunction

  function automatic mat2_t mk(input int x11, input int x12, input int x21, input int x22);
    mat2_t res;
    res.e11 = 16'(x11);
    res.e12 = 16'(x12);
    res.e21 = 16'(x21);
    res.e22 = 16'(x22);
    return res;
  endfunction

  function automatic mat2_t rand_mat();
    return mat2_t'({$urandom, $urandom});
  endfunction

  task automatic model_accept();
    mat2_t x, y;
    cvec_t p;
    x = mk(int'($signed(a11)), int'($signed(a12)), int'($signed(a21)), int'($signed(a22)));
    y = mk(int'($signed(b11)), int'($signed(b12)), int'($signed(b21)), int'($signed(b22)));
    p = matmul(x, y);
`ifdef STRASSEN_ACC_EN
    for (int i = 0; i < 4; i++) m_acc[i] = (in_first ? '0 : m_acc[i]) + p[i];
    if (in_last) begin
      exp_q.push_back(m_acc);
      m_acc = '0;
    end
`else
    exp_q.push_back(p);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic drive(input mat2_t x, input mat2_t y, input logic f, input logic l);
    a11 = x.e11; a12 = x.e12; a21 = x.e21; a22 = x.e22;
    b11 = y.e11; b12 = y.e12; b21 = y.e21; b22 = y.e22;
    in_first = f;
    in_last  = l;
  endtask

  // Samples handshakes on the falling edge, then steps to just after the rising edge.
  task automatic tick(output logic acc_o, output logic ret_o, output logic rdy_o,
                      output logic ov_o, output cvec_t got_o);
    @(negedge clk);
    acc_o = in_valid && in_ready;
    ret_o = out_valid && out_ready;
    rdy_o = in_ready;
    ov_o  = out_valid;
    got_o = {c11, c12, c21, c22};
    if (acc_o) model_accept();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if ({c11, c12, c21, c22} !== '0) begin errors++; $display("FAIL reset_c got=%h want=0", {c11, c12, c21, c22}); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_directed(input string name, input mat2_t x, input mat2_t y, input cvec_t want);
    logic acc_f, ret_f, rdy_f, ov_f;
    cvec_t got, e;
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(x, y, 1'b1, 1'b1);
    tick(acc_f, ret_f, rdy_f, ov_f, got);
    checks++;
    if (acc_f !== 1'b1) begin errors++; $display("FAIL %s_accept got=%b want=1", name, acc_f); end
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      tick(acc_f, ret_f, rdy_f, ov_f, got);
      if (ret_f) begin
        lat = k;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_model unexpected result got=%h", name, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL %s_model got=%h want=%h", name, got, e); end
        end
        checks++;
        if (got !== want) begin errors++; $display("FAIL %s_value got=%h want=%h", name, got, want); end
      end
    end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, LAT); end
  endtask

  task automatic test_back_to_back();
    logic acc_f, ret_f, rdy_f, ov_f;
    cvec_t got, e, held;
    int sent, n_out, stall;
    bit stalled_once;
    sent = 0; n_out = 0; stall = 0; stalled_once = 0; held = '0;
    drive(rand_mat(), rand_mat(), 1'b1, 1'b1);
    for (int cyc = 0; cyc < 100 && !(sent == 8 && n_out == 8); cyc++) begin
      if (sent == 5 && !stalled_once) begin stalled_once = 1; stall = 5; end
      out_ready = (stall == 0);
      in_valid  = (sent < 8);
      tick(acc_f, ret_f, rdy_f, ov_f, got);
      if (stall > 0) begin
        if (stall == 5) begin
          held = got;
          checks++;
          if (ov_f !== 1'b1) begin errors++; $display("FAIL b2b_stall_out_valid got=%b want=1", ov_f); end
        end else begin
          checks++;
          if (got !== held) begin errors++; $display("FAIL b2b_held_output got=%h want=%h", got, held); end
        end
        checks++;
        if (rdy_f !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready got=%b want=0", rdy_f); end
        stall--;
      end
      if (ret_f) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_result unexpected got=%h", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL b2b_result idx=%0d got=%h want=%h", n_out, got, e); end
        end
      end
      if (acc_f) begin
        sent++;
        drive(rand_mat(), rand_mat(), 1'b1, 1'b1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (n_out != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", n_out); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_random_flow();
    logic acc_f, ret_f, rdy_f, ov_f;
    cvec_t got, e;
    int sent;
    sent = 0;
    for (int cyc = 0; cyc < 800 && (sent < 30 || exp_q.size() > 0); cyc++) begin
      in_valid  = (sent < 30) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive(rand_mat(), rand_mat(), $urandom_range(0, 2) == 0, (sent == 29) || ($urandom_range(0, 2) == 0));
      tick(acc_f, ret_f, rdy_f, ov_f, got);
      if (ret_f) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_result unexpected got=%h", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL rand_result got=%h want=%h", got, e); end
        end
      end
      if (acc_f) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent != 30 || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain sent=%0d want=30 pending=%0d want=0", sent, exp_q.size());
    end
  endtask

`ifdef STRASSEN_ACC_EN
  task automatic test_acc_group(input string name, input mat2_t x0, input mat2_t y0, input logic f0, input logic l0,
                                input mat2_t x1, input mat2_t y1, input logic f1, input logic l1,
                                input int beats, input cvec_t want);
    logic acc_f, ret_f, rdy_f, ov_f;
    cvec_t got, e;
    int n_out, n_acc;
    n_out = 0; n_acc = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      in_valid = (k < beats);
      if (k == 0) drive(x0, y0, f0, l0);
      else drive(x1, y1, f1, l1);
      tick(acc_f, ret_f, rdy_f, ov_f, got);
      if (acc_f) n_acc++;
      if (ret_f) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_model unexpected got=%h", name, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin errors++; $display("FAIL %s_model got=%h want=%h", name, got, e); end
        end
        checks++;
        if (got !== want) begin errors++; $display("FAIL %s_value got=%h want=%h", name, got, want); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_acc != beats) begin errors++; $display("FAIL %s_accepts got=%0d want=%0d", name, n_acc, beats); end
    checks++;
    if (n_out != 1) begin errors++; $display("FAIL %s_outputs got=%0d want=1", name, n_out); end
  endtask
`endif

  task automatic test_reset_midflight();
    logic acc_f, ret_f, rdy_f, ov_f;
    cvec_t got;
    int sent, n_out;
    sent = 0; n_out = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && sent < 3; cyc++) begin
      in_valid = 1'b1;
      drive(rand_mat(), rand_mat(), 1'b1, 1'b1);
      tick(acc_f, ret_f, rdy_f, ov_f, got);
      if (acc_f) sent++;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++;
    if ({c11, c12, c21, c22} !== '0) begin errors++; $display("FAIL midrst_c got=%h want=0", {c11, c12, c21, c22}); end
    exp_q.delete();
    m_acc = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(acc_f, ret_f, rdy_f, ov_f, got);
      if (ov_f) n_out++;
    end
    checks++;
    if (n_out != 0) begin errors++; $display("FAIL midrst_stale got=%0d want=0", n_out); end
    test_directed("post_reset", mk(1, 2, 3, 4), mk(5, 6, 7, 8), cv(19, 22, 43, 50));
  endtask

  initial begin
    test_reset();
    test_directed("basic", mk(1, 2, 3, 4), mk(5, 6, 7, 8), cv(19, 22, 43, 50));
    test_directed("neg_ident", mk(-1, 0, 0, -1), mk(3, 4, 5, 6), cv(-3, -4, -5, -6));
    test_directed("min_all", mk(-32768, -32768, -32768, -32768), mk(-32768, -32768, -32768, -32768),
                  cv(64'sd2147483648, 64'sd2147483648, 64'sd2147483648, 64'sd2147483648));
    test_back_to_back();
`ifdef STRASSEN_ACC_EN
    test_acc_group("acc_two", mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b1, 1'b0,
                   mk(1, 0, 0, 1), mk(1, 1, 1, 1), 1'b0, 1'b1, 2, cv(20, 23, 44, 51));
    test_acc_group("acc_after_group", mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b0, 1'b1,
                   mk(0, 0, 0, 0), mk(0, 0, 0, 0), 1'b0, 1'b0, 1, cv(19, 22, 43, 50));
`endif
    test_random_flow();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
